// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: tracks E/M/W destination records, raises stall/bubble and forward selects.
// Optional build macro HAZARD_PERF_CNT_EN adds perf_stall_cnt and perf_md_stall_cnt counters.
module hazard_stall_unit #(
  parameter int TW = 2,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic [RW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_is_md,
  input  logic          mdu_busy,
  output logic          stall,
  output logic          e_bubble,
  output logic [1:0]    d_fwd_rs,
  output logic [1:0]    d_fwd_rt
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_md_stall_cnt
`endif
);

  logic [RW-1:0] e_dst_reg, e_dst_next;
  logic [TW-1:0] e_tnew_reg, e_tnew_next;
  logic [RW-1:0] m_dst_reg, m_dst_next;
  logic [TW-1:0] m_tnew_reg, m_tnew_next;
  logic [RW-1:0] w_dst_reg, w_dst_next;

  logic [RW-1:0] src  [2];
  logic [TW-1:0] tuse [2];
  logic [1:0]    reg_hit;
  logic [1:0]    fwd_sel [2];
  logic          md_stall;

  assign src[0]  = d_rs;
  assign src[1]  = d_rt;
  assign tuse[0] = d_rs_tuse;
  assign tuse[1] = d_rt_tuse;

  // The youngest matching record decides: a match still in flight blocks older, stale copies.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic live, e_match, m_match, w_match;
      assign live    = d_valid && (src[gi] != '0);
      assign e_match = live && (e_dst_reg == src[gi]);
      assign m_match = live && (m_dst_reg == src[gi]);
      assign w_match = live && (w_dst_reg == src[gi]);
      assign reg_hit[gi] = (e_match && (e_tnew_reg > tuse[gi])) ||
                           (m_match && (m_tnew_reg > tuse[gi]));
      assign fwd_sel[gi] = e_match ? ((e_tnew_reg == '0) ? 2'd1 : 2'd0) :
                           m_match ? ((m_tnew_reg == '0) ? 2'd2 : 2'd0) :
                           w_match ? 2'd3 : 2'd0;
    end
  endgenerate

  assign md_stall = d_valid && d_is_md && mdu_busy;
  assign stall    = (|reg_hit) || md_stall;
  assign e_bubble = stall;
  assign d_fwd_rs = fwd_sel[0];
  assign d_fwd_rt = fwd_sel[1];

  always_comb begin
    e_dst_next  = '0;
    e_tnew_next = '0;
    if (!stall && d_valid) begin
      e_dst_next  = d_dst;
      e_tnew_next = d_tnew;
    end
    m_dst_next  = e_dst_reg;
    m_tnew_next = (e_tnew_reg == '0) ? '0 : e_tnew_reg - TW'(1);
    w_dst_next  = m_dst_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_dst_reg  <= '0;
      e_tnew_reg <= '0;
      m_dst_reg  <= '0;
      m_tnew_reg <= '0;
      w_dst_reg  <= '0;
    end else begin
      e_dst_reg  <= e_dst_next;
      e_tnew_reg <= e_tnew_next;
      m_dst_reg  <= m_dst_next;
      m_tnew_reg <= m_tnew_next;
      w_dst_reg  <= w_dst_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_reg, perf_md_stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt_reg    <= '0;
      perf_md_stall_cnt_reg <= '0;
    end else begin
      if (stall)    perf_stall_cnt_reg    <= perf_stall_cnt_reg + 32'd1;
      if (md_stall) perf_md_stall_cnt_reg <= perf_md_stall_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt    = perf_stall_cnt_reg;
  assign perf_md_stall_cnt = perf_md_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: expectations queued when stimulus is driven, checked before the next edge.
module tb_hazard_stall_unit;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_is_md, mdu_busy;
  logic       stall, e_bubble;
  logic [1:0] d_fwd_rs, d_fwd_rt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_md_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] frs;
    logic [1:0] frt;
  } exp_t;
  exp_t sb[$];

  hazard_stall_unit #(.TW(2), .RW(5)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_is_md(d_is_md), .mdu_busy(mdu_busy),
    .stall(stall), .e_bubble(e_bubble), .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_md_stall_cnt(perf_md_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rs_tu,
                       input logic [4:0] rt, input logic [1:0] rt_tu,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic md, input logic busy);
    d_valid = v; d_rs = rs; d_rs_tuse = rs_tu; d_rt = rt; d_rt_tuse = rt_tu;
    d_dst = dst; d_tnew = tn; d_is_md = md; mdu_busy = busy;
  endtask

  task automatic expect_now(input string tag, input logic st, input logic [1:0] fr, input logic [1:0] ft);
    exp_t e;
    e.tag = tag; e.st = st; e.frs = fr; e.frt = ft;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".stall"}, {31'd0, stall}, {31'd0, e.st});
      cmp({e.tag, ".e_bubble"}, {31'd0, e_bubble}, {31'd0, e.st});
      cmp({e.tag, ".fwd_rs"}, {30'd0, d_fwd_rs}, {30'd0, e.frs});
      cmp({e.tag, ".fwd_rt"}, {30'd0, d_fwd_rt}, {30'd0, e.frt});
    end
    $display("step %-14s t=%0t stall=%0b bubble=%0b fwd_rs=%0d fwd_rt=%0d", tag, $time, stall, e_bubble, d_fwd_rs, d_fwd_rt);
  endtask

  // One cycle: drive D-stage inputs after the falling edge, check before the rising edge.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic [1:0] rs_tu,
                     input logic [4:0] rt, input logic [1:0] rt_tu,
                     input logic [4:0] dst, input logic [1:0] tn, input logic md, input logic busy,
                     input logic st, input logic [1:0] fr, input logic [1:0] ft);
    @(negedge clk);
    drive(v, rs, rs_tu, rt, rt_tu, dst, tn, md, busy);
    expect_now(tag, st, fr, ft);
  endtask

  task automatic flush();
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 5'd1, 2'd0, 5'd1, 2'd0, 5'd1, 2'd2, 1'b0, 1'b0);
    expect_now("reset", 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    cmp("reset.perf_stall", perf_stall_cnt, 32'd0);
    cmp("reset.perf_md", perf_md_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    flush();

    // Load-use: load r1 enters E, consumer needs r1 in E
    cyc("lu_load", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    cyc("lu_stall", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("lu_release", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush();

    // Branch after ALU on rt
    cyc("br_alu", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    cyc("br_stall", 1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("br_fwd_m", 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2);
    flush();

    // MD busy for six cycles stalls an mflo; addu and invalid D do not stall
    for (int i = 0; i < 6; i++)
      cyc($sformatf("md_busy%0d", i), 1, 0, 0, 0, 0, 2, 1, 1, 1, 1, 0, 0);
    cyc("md_release", 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    flush();
    cyc("addu_busy", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("md_invalid", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    flush();

    // Register zero
    cyc("zero_load", 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    cyc("zero_src", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush();

    // Forward priority E > M > W
    cyc("pri_fill0", 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    cyc("pri_fill1", 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    cyc("pri_fill2", 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    cyc("pri_e", 1, 5, 0, 5, 0, 5, 0, 0, 0, 0, 1, 1);
    cyc("pri_invalid", 0, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("pri_m", 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 2, 2);
    cyc("pri_w", 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 3, 3);
    cyc("pri_none", 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    flush();

    // Asynchronous reset while stalled
    cyc("ar_load", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    cyc("ar_stall", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 reset = 1'b1;
    expect_now("ar_asserted", 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    cmp("ar.perf_stall", perf_stall_cnt, 32'd0);
    cmp("ar.perf_md", perf_md_stall_cnt, 32'd0);
`endif
    reset = 1'b0;
    expect_now("ar_cleared", 1'b0, 2'd0, 2'd0);

    // Three stall cycles: load-use on r1 with an MD op waiting on a busy MDU
    cyc("pc_load", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    cyc("pc_s0", 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    cyc("pc_s1", 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    cyc("pc_s2", 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0);
    cyc("pc_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    cmp("pc.perf_stall", perf_stall_cnt, 32'd3);
    cmp("pc.perf_md", perf_md_stall_cnt, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decode-stage hazard controller sitting directly upstream of the multiply/divide unit and the E stage.
- Keeps shadow records (dest reg, Tnew) of instructions in E, M and W.
- Compares them with the D-stage instruction's source registers and Tuse, and consumes the MDU busy flag.
- Drives the pipeline freeze (stall), the E-stage bubble and the D-stage forward selects. No MDU operation issues while the MDU is busy.

Parameters:
- TW, 2, width of Tnew/Tuse fields.
- RW, 5, register index width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all records
- d_valid  in  1  D-stage holds a real instruction
- d_rs  in  RW  D source reg A
- d_rt  in  RW  D source reg B
- d_rs_tuse  in  TW  cycles until rs needed (0 = D, 1 = E, 2 = M)
- d_rt_tuse  in  TW  same for rt
- d_dst  in  RW  D destination reg (0 = none)
- d_tnew  in  TW  cycles after E entry until result ready (ALU/mf = 1, load = 2)
- d_is_md  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- mdu_busy  in  1  MDU busy, including combinational start
- stall  out  1  freeze PC and F/D register
- e_bubble  out  1  load NOP into D/E register
- d_fwd_rs  out  2  0 none, 1 E-out, 2 M-out, 3 W-out
- d_fwd_rt  out  2  same for rt

Behaviour:
- Records:
  - E = {dst, tnew}, M = {dst, tnew}, W = {dst}.
  - On reset, all dst = 0 and tnew = 0, asynchronously.
- Per-clock update, not stalled:
  - E <= d_valid ? {d_dst, d_tnew} : {0, 0}.
  - M <= {E.dst, sat(E.tnew-1)}.
  - W <= M.dst.
- Per-clock update, stalled:
  - E <= {0, 0} (bubble).
  - M and W advance as above.
- Register-hazard match: a source s (rs or rt) matches record R when s != 0 && R.dst == s.
- Register stall: true when a source with D-valid matches E with E.tnew > tuse, or matches M with M.tnew > tuse.
- MD stall: d_valid && d_is_md && mdu_busy.
- Outputs are combinational from records and D inputs:
  - stall = register stall | MD stall.
  - e_bubble = stall.
- Forward select for each source:
  - Choose the youngest matching record whose tnew == 0, priority E > M > W (W tnew is always 0).
  - A matching record with tnew > 0 gives 0. This is not a stall if tnew ≤ tuse; E-stage forwarding resolves it later.
  - When d_valid = 0, select is 0.
- Register 0 never matches, never stalls and never forwards.
- rs and rt are evaluated independently. A hit on either one stalls.
- Reset values (records cleared): stall = 0, e_bubble = 0, d_fwd_* = 0 for any D input.
- Reset asserted mid-stall: outputs drop in the same cycle, with no clock edge needed.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cnt (32, out) and perf_md_stall_cnt (32, out).
  - perf_stall_cnt increments on each clock with stall = 1.
  - perf_md_stall_cnt increments on each clock with MD stall = 1.
  - Both wrap 0xFFFFFFFF -> 0 and are cleared by reset.
- When undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Load-use: E = {dst 1, tnew 2}; D: rs = 1, tuse = 1, d_valid = 1.
  - Cycle 0: stall = 1, e_bubble = 1.
  - Next cycle: M.tnew = 1 and E is a bubble, so stall = 0, d_fwd_rs = 0.
- Branch after ALU: E = {dst 3, tnew 1}; D: rt = 3, tuse = 0.
  - Stall for 1 cycle.
  - Next cycle: M = {3, 0}, stall = 0, d_fwd_rt = 2.
- MD busy: mult in E (mdu_busy = 1 for 6 cycles); D = mflo, d_is_md = 1.
  - stall = 1 for exactly 6 cycles.
  - Released on the first cycle mdu_busy = 0.
  - A non-MD addu in D during busy gives stall = 0.
- Zero register: E = {dst 0, tnew 2}; D: rs = 0, tuse = 0.
  - stall = 0, d_fwd_rs = 0.
- Forward priority: E = {5, 0}, M = {5, 0}, W = 5; D: rs = 5.
  - d_fwd_rs = 1.
  - Clearing E (bubble) gives 2.
  - Then only W matching gives 3.
- Async reset mid-stall: assert reset between edges while stall = 1.
  - stall = 0 immediately; records clear.
  - With HAZARD_PERF_CNT_EN defined, both counters read 0 and then count 3 after a 3-cycle load-use stall sequence.
